// File: rtl/instr_encoder_if.sv
// ============================================================================
// instr_encoder_if : request / instruction-memory write bus of instr_encoder
// Rev 1.0
// ============================================================================
`default_nettype none

interface instr_encoder_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic [3:0]        req_cond;
  logic [2:0]        req_cmd;
  logic              req_s;
  logic [3:0]        req_rd;
  logic [3:0]        req_rn;
  logic [3:0]        req_rm;
  logic [23:0]       req_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              err;

  modport master (
    output base_load, base_addr, req_valid, req_kind, req_cond, req_cmd,
           req_s, req_rd, req_rn, req_rm, req_imm,
    input  req_ready, imem_we, imem_addr, imem_wd, word_count, busy, err
  );

  modport slave (
    input  base_load, base_addr, req_valid, req_kind, req_cond, req_cmd,
           req_s, req_rd, req_rn, req_rm, req_imm,
    output req_ready, imem_we, imem_addr, imem_wd, word_count, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder : field-level requests -> 32-bit ARM words written to imem
// Optional illegal-request check enabled by macro ENC_CHECK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  wire logic        clk,
  input  wire logic        reset,
  instr_encoder_if.slave   bus
);

  localparam logic [2:0] c_KIND_DPR = 3'd0;
  localparam logic [2:0] c_KIND_DPI = 3'd1;
  localparam logic [2:0] c_KIND_LDR = 3'd2;
  localparam logic [2:0] c_KIND_STR = 3'd3;
  localparam logic [2:0] c_KIND_B   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wd;
  logic [CNT_W-1:0]  r_count;
  logic              r_busy;

  logic [2:0]        r_kind;
  logic [3:0]        r_cond;
  logic [2:0]        r_cmd;
  logic              r_s;
  logic [3:0]        r_rd;
  logic [3:0]        r_rn;
  logic [3:0]        r_rm;
  logic [23:0]       r_imm;

  logic [3:0]        w_opc;
  logic [31:0]       w_word;
  logic              w_illegal;

  always_comb begin
    w_opc = 4'b0000;
    case (r_cmd)
      3'd0:    w_opc = 4'b0100;
      3'd1:    w_opc = 4'b0010;
      3'd2:    w_opc = 4'b0000;
      3'd3:    w_opc = 4'b1100;
      3'd4:    w_opc = 4'b0001;
      default: w_opc = 4'b0000;
    endcase
  end

  // Illegal kinds fall into the DP-reg layout when not trapped
  always_comb begin
    w_word = '0;
    case (r_kind)
      c_KIND_LDR, c_KIND_STR:
        w_word = {r_cond, 2'b01, 5'b01100, (r_kind == c_KIND_LDR), r_rn, r_rd, r_imm[11:0]};
      c_KIND_B:
        w_word = {r_cond, 4'b1010, r_imm};
      c_KIND_DPI:
        w_word = {r_cond, 2'b00, 1'b1, w_opc, r_s, r_rn, r_rd, r_imm[11:0]};
      default:
        w_word = {r_cond, 2'b00, 1'b0, w_opc, r_s, r_rn, r_rd, 8'h00, r_rm};
    endcase
  end

`ifdef ENC_CHECK_EN
  logic r_err;

  always_comb begin
    w_illegal = (r_kind > c_KIND_B) ||
                (((r_kind == c_KIND_DPR) || (r_kind == c_KIND_DPI)) && (r_cmd > 3'd4));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_ENC) && w_illegal;
    end
  end

  assign bus.err = r_err;
`else
  always_comb begin
    w_illegal = 1'b0;
  end

  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_kind  <= '0;
      r_cond  <= '0;
      r_cmd   <= '0;
      r_s     <= 1'b0;
      r_rd    <= '0;
      r_rn    <= '0;
      r_rm    <= '0;
      r_imm   <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A base load in the same cycle as an accept steers that word to the new base
          if (bus.base_load) begin
            r_addr  <= bus.base_addr & ~ADDR_W'(3);
            r_count <= '0;
          end
          if (bus.req_valid && r_ready) begin
            r_kind  <= bus.req_kind;
            r_cond  <= bus.req_cond;
            r_cmd   <= bus.req_cmd;
            r_s     <= bus.req_s;
            r_rd    <= bus.req_rd;
            r_rn    <= bus.req_rn;
            r_rm    <= bus.req_rm;
            r_imm   <= bus.req_imm;
            r_state <= S_ENC;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_ENC: begin
          if (w_illegal) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_wd    <= w_word;
            r_we    <= 1'b1;
            r_state <= S_WR;
          end
        end
        S_WR: begin
          r_addr <= r_addr + ADDR_W'(4);
          if (r_count != '1) begin
            r_count <= r_count + 1'b1;
          end
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wd    = r_wd;
  assign bus.word_count = r_count;
  assign bus.busy       = r_busy;

endmodule

`default_nettype wire
